// File: rtl/alu_issue_queue.sv
// alu_issue_queue: request FIFO in front of an external combinational ALU.
// Requests are queued, issued one at a time onto registered ALU inputs that are held stable
// for SETTLE_CYCLES edges, and then the ALU outputs are captured into a response register
// that is held until the downstream handshake completes.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   req_valid/req_ready             request handshake; req_command/req_operandA/req_operandB
//   alu_command/alu_operandA/B      registered drive into the ALU
//   alu_result/carryout/zero/overflow  ALU outputs, sampled at capture
//   rsp_valid/rsp_ready             response handshake; rsp_* hold the captured result
//   busy                            FIFO non-empty or an operation in flight
module alu_issue_queue #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_command,
    input  logic [31:0] req_operandA,
    input  logic [31:0] req_operandB,
    output logic [2:0]  alu_command,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    input  logic [31:0] alu_result,
    input  logic        alu_carryout,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_command,
    output logic [31:0] rsp_result,
    output logic        rsp_carryout,
    output logic        rsp_zero,
    output logic        rsp_overflow,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
    localparam logic [AW:0]   DEPTH_CNT   = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic [2:0]    cmd_mem [DEPTH];
    logic [31:0]   a_mem   [DEPTH];
    logic [31:0]   b_mem   [DEPTH];

    logic [2:0]    alu_command_d;
    logic [31:0]   alu_operandA_d, alu_operandB_d;
    logic          rsp_valid_d;
    logic [2:0]    rsp_command_d;
    logic [31:0]   rsp_result_d;
    logic          rsp_carryout_d, rsp_zero_d, rsp_overflow_d;

    logic          push, pop;

    // Registered-only ready: depends on count_q alone.
    assign req_ready = (count_q < DEPTH_CNT);
    assign push      = req_valid && req_ready;
    assign busy      = (count_q != '0) || (state_q != StIdle);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pop            = 1'b0;
        alu_command_d  = alu_command;
        alu_operandA_d = alu_operandA;
        alu_operandB_d = alu_operandB;
        rsp_valid_d    = rsp_valid;
        rsp_command_d  = rsp_command;
        rsp_result_d   = rsp_result;
        rsp_carryout_d = rsp_carryout;
        rsp_zero_d     = rsp_zero;
        rsp_overflow_d = rsp_overflow;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    alu_command_d  = cmd_mem[rd_ptr_q];
                    alu_operandA_d = a_mem[rd_ptr_q];
                    alu_operandB_d = b_mem[rd_ptr_q];
                    cnt_d          = SETTLE_LOAD;
                    state_d        = StSettle;
                end
            end
            StSettle: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    rsp_command_d  = cmd_mem[rd_ptr_q];
                    rsp_result_d   = alu_result;
                    rsp_carryout_d = alu_carryout;
                    rsp_zero_d     = alu_zero;
                    rsp_overflow_d = alu_overflow;
                    rsp_valid_d    = 1'b1;
                    pop            = 1'b1;
                    state_d        = StHold;
                end
            end
            StHold: begin
                // rsp_valid is always high here, so rsp_ready completes the handshake.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            alu_command  <= '0;
            alu_operandA <= '0;
            alu_operandB <= '0;
            rsp_valid    <= 1'b0;
            rsp_command  <= '0;
            rsp_result   <= '0;
            rsp_carryout <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            // Pointers wrap naturally since DEPTH is a power of two.
            wr_ptr_q     <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q     <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_q      <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
            alu_command  <= alu_command_d;
            alu_operandA <= alu_operandA_d;
            alu_operandB <= alu_operandB_d;
            rsp_valid    <= rsp_valid_d;
            rsp_command  <= rsp_command_d;
            rsp_result   <= rsp_result_d;
            rsp_carryout <= rsp_carryout_d;
            rsp_zero     <= rsp_zero_d;
            rsp_overflow <= rsp_overflow_d;
        end
    end

    // Storage needs no reset: count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            cmd_mem[wr_ptr_q] <= req_command;
            a_mem[wr_ptr_q]   <= req_operandA;
            b_mem[wr_ptr_q]   <= req_operandB;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SETTLE = 8;

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_SLT  = 3'd3;
    localparam logic [2:0] CMD_AND  = 3'd4;
    localparam logic [2:0] CMD_NAND = 3'd5;
    localparam logic [2:0] CMD_NOR  = 3'd6;
    localparam logic [2:0] CMD_OR   = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_command = '0;
    logic [31:0] req_operandA = '0;
    logic [31:0] req_operandB = '0;
    logic [2:0]  alu_command;
    logic [31:0] alu_operandA, alu_operandB;
    logic [31:0] alu_result;
    logic        alu_carryout, alu_zero, alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [2:0]  rsp_command;
    logic [31:0] rsp_result;
    logic        rsp_carryout, rsp_zero, rsp_overflow;
    logic        busy;

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_command(req_command),
        .req_operandA(req_operandA), .req_operandB(req_operandB),
        .alu_command(alu_command), .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
        .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_command(rsp_command),
        .rsp_result(rsp_result), .rsp_carryout(rsp_carryout), .rsp_zero(rsp_zero),
        .rsp_overflow(rsp_overflow), .busy(busy)
    );

    // Reference ALU: returns {carryout, zero, overflow, result}.
    function automatic logic [34:0] alu_ref(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        co, ov;
        s = '0; r = '0; co = 1'b0; ov = 1'b0;
        case (c)
            CMD_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            CMD_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; co = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            CMD_XOR:  r = a ^ b;
            CMD_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            CMD_AND:  r = a & b;
            CMD_NAND: r = ~(a & b);
            CMD_NOR:  r = ~(a | b);
            CMD_OR:   r = a | b;
            default:  r = '0;
        endcase
        return {co, (r == 32'd0), ov, r};
    endfunction

    always_comb {alu_carryout, alu_zero, alu_overflow, alu_result} =
        alu_ref(alu_command, alu_operandA, alu_operandB);

    int n_check = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_check++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Transaction-level model: pending entries in order, one operation in flight whose
    // capture edge is known in advance, and a held response.
    logic [66:0] mq[$];
    logic        m_inflight = 1'b0;
    logic        m_hold = 1'b0;
    int          m_cap_n = 0;
    logic [66:0] m_alu = '0;
    logic [37:0] m_rsp = '0;
    int          n = 0;
    logic        chk_en = 1'b0;

    logic [37:0] got[$];
    int          got_n[$];
    int          first_rsp_n = -1;

    task automatic model_edge();
        logic [66:0] e;
        logic        ready;
        n++;
        if (reset) begin
            mq.delete();
            m_inflight = 1'b0; m_hold = 1'b0;
            m_alu = '0; m_rsp = '0;
            return;
        end
        ready = (mq.size() < DEPTH);
        if (m_hold) begin
            if (rsp_ready) m_hold = 1'b0;
        end else if (m_inflight) begin
            if (n == m_cap_n) begin
                e = mq.pop_front();
                m_rsp = {e[66:64], alu_ref(e[66:64], e[63:32], e[31:0])};
                m_hold = 1'b1;
                m_inflight = 1'b0;
            end
        end else if (mq.size() > 0) begin
            m_alu = mq[0];
            m_inflight = 1'b1;
            m_cap_n = n + SETTLE;
        end
        if (req_valid && ready) mq.push_back({req_command, req_operandA, req_operandB});
    endtask

    task automatic check_outputs();
        check("req_ready", 72'(req_ready), 72'(mq.size() < DEPTH));
        check("busy", 72'(busy), 72'((mq.size() != 0) || m_inflight || m_hold));
        check("rsp_valid", 72'(rsp_valid), 72'(m_hold));
        check("rsp_fields",
              72'({rsp_command, rsp_carryout, rsp_zero, rsp_overflow, rsp_result}), 72'(m_rsp));
        check("alu_drive", 72'({alu_command, alu_operandA, alu_operandB}), 72'(m_alu));
    endtask

    // Called at a negedge: check, drive, cross one posedge, return at the next negedge.
    task automatic tick(input logic rst, input logic v, input logic [2:0] c,
                        input logic [31:0] a, input logic [31:0] b, input logic rr);
        if (chk_en) begin
            check_outputs();
            if (rsp_valid && first_rsp_n < 0) first_rsp_n = n;
            if (!rst && rsp_valid && rr) begin
                got.push_back({rsp_command, rsp_carryout, rsp_zero, rsp_overflow, rsp_result});
                got_n.push_back(n + 1);
            end
        end
        reset = rst; req_valid = v; req_command = c;
        req_operandA = a; req_operandB = b; rsp_ready = rr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int cycles, input logic rr);
        for (int i = 0; i < cycles; i++) tick(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, rr);
    endtask

    initial begin
        int base, gbase, push_n, offered;
        int acc_rel[$];
        logic acc;
        logic [31:0] ra, rb;

        @(negedge clk);
        tick(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        chk_en = 1'b1;
        tick(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        check("reset_rsp_valid", 72'(rsp_valid), 72'(0));
        check("reset_req_ready", 72'(req_ready), 72'(1));
        check("reset_busy", 72'(busy), 72'(0));

        // ADD 1+2 and its latency
        first_rsp_n = -1;
        push_n = n + 1;
        tick(1'b0, 1'b1, CMD_ADD, 32'd1, 32'd2, 1'b1);
        idle(15, 1'b1);
        check("add_latency", 72'(first_rsp_n - push_n), 72'(SETTLE + 1));
        gbase = got.size();
        check("add_count", 72'(gbase), 72'(1));
        if (gbase >= 1) check("add_rsp", 72'(got[0]), 72'({CMD_ADD, 3'b000, 32'd3}));

        // SUB 3-3
        tick(1'b0, 1'b1, CMD_SUB, 32'd3, 32'd3, 1'b1);
        idle(12, 1'b1);
        check("sub_count", 72'(got.size()), 72'(gbase + 1));
        if (got.size() == gbase + 1)
            check("sub_rsp", 72'(got[gbase]), 72'({CMD_SUB, 3'b110, 32'd0}));

        // Six back-to-back offers with the response path stalled
        base = n; offered = 0;
        for (int i = 0; i < 20; i++) begin
            acc = (offered < 6) && req_ready;
            tick(1'b0, offered < 6, CMD_ADD, 32'(offered), 32'd100, 1'b0);
            if (acc) begin
                acc_rel.push_back(n - base - 1);
                offered++;
            end
        end
        check("full_accepts", 72'(acc_rel.size()), 72'(5));
        if (acc_rel.size() == 5) begin
            check("full_acc3", 72'(acc_rel[3]), 72'(3));
            check("full_acc4", 72'(acc_rel[4]), 72'(SETTLE + 2));
        end
        check("full_ready", 72'(req_ready), 72'(0));
        check("full_held", 72'(rsp_valid), 72'(1));
        idle(80, 1'b1);

        // XOR, SLT, NAND back-to-back: order and spacing
        gbase = got.size();
        tick(1'b0, 1'b1, CMD_XOR, 32'd1, 32'd1, 1'b1);
        tick(1'b0, 1'b1, CMD_SLT, 32'd2, 32'd3, 1'b1);
        tick(1'b0, 1'b1, CMD_NAND, 32'd0, 32'd0, 1'b1);
        idle(40, 1'b1);
        check("order_count", 72'(got.size() - gbase), 72'(3));
        if (got.size() - gbase == 3) begin
            check("order_xor", 72'(got[gbase][31:0]), 72'(32'd0));
            check("order_slt", 72'(got[gbase + 1][31:0]), 72'(32'd1));
            check("order_nand", 72'(got[gbase + 2][31:0]), 72'(32'hFFFF_FFFF));
            check("gap1", 72'(got_n[gbase + 1] - got_n[gbase] >= SETTLE + 1), 72'(1));
            check("gap2", 72'(got_n[gbase + 2] - got_n[gbase + 1] >= SETTLE + 1), 72'(1));
        end

        // Reset three edges into SETTLE with entries queued
        gbase = got.size();
        tick(1'b0, 1'b1, CMD_ADD, 32'd5, 32'd5, 1'b1);
        tick(1'b0, 1'b1, CMD_ADD, 32'd6, 32'd6, 1'b1);
        tick(1'b0, 1'b1, CMD_ADD, 32'd7, 32'd7, 1'b1);
        idle(2, 1'b1);
        tick(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        check("rst_mid_valid", 72'(rsp_valid), 72'(0));
        check("rst_mid_busy", 72'(busy), 72'(0));
        check("rst_mid_ready", 72'(req_ready), 72'(1));
        idle(20, 1'b1);
        check("rst_no_rsp", 72'(got.size()), 72'(gbase));

        // Push on the same edge as the capture pop with two entries present
        gbase = got.size();
        tick(1'b0, 1'b1, CMD_ADD, 32'd10, 32'd1, 1'b0);
        tick(1'b0, 1'b1, CMD_ADD, 32'd20, 32'd2, 1'b0);
        idle(SETTLE - 1, 1'b0);
        tick(1'b0, 1'b1, CMD_ADD, 32'd30, 32'd3, 1'b0);
        check("pp_ready", 72'(req_ready), 72'(1));
        idle(50, 1'b1);
        check("pp_count", 72'(got.size() - gbase), 72'(3));
        if (got.size() - gbase == 3) begin
            check("pp_first", 72'(got[gbase][31:0]), 72'(32'd11));
            check("pp_last", 72'(got[gbase + 2][31:0]), 72'(32'd33));
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            tick($urandom_range(0, 399) == 0, $urandom_range(0, 1) == 1,
                 3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 3) != 0);
        end
        idle(60, 1'b1);
        check("final_idle", 72'(busy), 72'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_check, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: request FIFO entries, power of two, at least 2.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8: clock edges the ALU inputs are held stable before capture, at least 1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  upstream request present.
REQ-006 SHALL have port req_ready  output  1  FIFO can accept a request.
REQ-007 SHALL have port req_command  input  3  ALU command (`COMMAND_* encoding).
REQ-008 SHALL have port req_operandA  input  32  operand A.
REQ-009 SHALL have port req_operandB  input  32  operand B.
REQ-010 SHALL have ports alu_command (output 3), alu_operandA (output 32) and alu_operandB (output 32): registered drive into the ALU.
REQ-011 SHALL have ports alu_result (input 32), alu_carryout (input 1), alu_zero (input 1) and alu_overflow (input 1): ALU outputs.
REQ-012 SHALL have port rsp_valid  output  1  response held.
REQ-013 SHALL have port rsp_ready  input  1  downstream accepts response.
REQ-014 SHALL have ports rsp_command (output 3), rsp_result (output 32), rsp_carryout (output 1), rsp_zero (output 1) and rsp_overflow (output 1): captured response.
REQ-015 SHALL have port busy  output  1  high when the FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-016 SHALL push {command, operandA, operandB} on an edge with req_valid and req_ready both high.
REQ-017 SHALL drive req_ready as (count < DEPTH) from registered state only; no combinational path from rsp_ready or req_valid.
REQ-018 SHALL wrap read and write pointers modulo DEPTH; push and pop on the same edge leave count unchanged.
REQ-019 SHALL implement FSM states IDLE, SETTLE and HOLD.
REQ-020 IDLE: if count > 0, SHALL load the FIFO head into the alu_* registers, load the counter with SETTLE_CYCLES and go to SETTLE; otherwise SHALL stay in IDLE.
REQ-021 SETTLE: SHALL decrement the counter each edge; on the edge where counter == 1 it SHALL capture alu_result/flags and the head command into rsp_*, pop the FIFO, set rsp_valid and go to HOLD.
REQ-022 HOLD: SHALL keep rsp_* and rsp_valid stable until rsp_valid and rsp_ready are both high, then clear rsp_valid and go to IDLE on that edge.
REQ-023 SHALL hold the alu_* registers unchanged outside IDLE->SETTLE loads, so they are stable throughout SETTLE.
REQ-024 Latency: a request accepted at edge t into an empty idle block SHALL produce rsp_valid high after edge t+1+SETTLE_CYCLES (t+9 by default).
REQ-025 SHALL issue responses strictly in acceptance order, one ALU operation in flight at a time.
REQ-026 SHALL still accept requests while in SETTLE or HOLD whenever count < DEPTH.
REQ-027 SHALL never modify operands or flags; rsp_* are exactly the ALU outputs sampled at capture.

Reset
REQ-028 With reset high at an edge, SHALL set state to IDLE, count and pointers to 0, and rsp_valid, req_ready-blocking state, alu_* and rsp_* to 0.
REQ-029 Reset SHALL take priority over push, pop, capture and handshake on the same edge.
REQ-030 Reset mid-SETTLE or mid-HOLD SHALL discard the in-flight operation and all queued entries; no response appears for them.
REQ-031 req_ready SHALL be 1 on the first edge after reset deasserts.

Verification
REQ-032 Push ADD, A=1, B=2 at edge 0 with rsp_ready=1 -> rsp_valid=1 after edge 9; rsp_result=3, carryout=0, zero=0, overflow=0, rsp_command=`COMMAND_ADD.
REQ-033 Push SUB 3-3 -> rsp_result=0, zero=1, carryout=1, overflow=0.
REQ-034 Hold rsp_ready=0 and offer 6 back-to-back requests -> 4 accepted at edges 0-3, 5th accepted only after the first capture pop, then req_ready=0 with rsp_valid held stable.
REQ-035 Push XOR 1^1, SLT 2<3, NAND 0,0 back-to-back -> responses in order: 0, 1, FFFFFFFF; each spaced by at least SETTLE_CYCLES+1 edges.
REQ-036 Assert reset 3 edges into SETTLE with 2 entries queued -> next edge rsp_valid=0, count=0, busy=0; no later responses appear.
REQ-037 Push on the same edge as a pop with count=2 -> count stays 2 and the pushed entry is returned last.
